// File: rtl/arb_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM state encodings, port ids
// and the default RAM geometry (1K x 32).
package arb_pkg;

    localparam int ARB_ADDR_W = 10;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational two-way request picker. With RR set, a tie goes to the port
// named by prio; with RR clear, the CPU port always wins when it requests.
module rr_pick
    import arb_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_id,
    output logic       gnt_valid
);

    // Choose a winner among the active requests.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
        gnt_valid = |req;
        gnt_id    = PORT_CPU;
        if (RR) begin
            if (req == 2'b11) begin
                gnt_id = prio;
            end else if (req[1]) begin
                gnt_id = PORT_DMA;
            end
        end else begin
            if (!req[0] && req[1]) begin
                gnt_id = PORT_DMA;
            end
        end
    end

endmodule : rr_pick

// File: rtl/ram_arbiter.sv
// Serialises CPU-bus (port 0) and DMA/loader (port 1) accesses onto the
// single-port data RAM. Each access takes IDLE -> ACCESS -> DONE, with the
// requester's ack pulsing in DONE.
module ram_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int RR     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dina,
    input  logic [DATA_W-1:0] ram_douta,
    output logic              busy
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_prio;
    logic              r_gnt_id;
    logic              r_gnt_we;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_dina;
    logic              w_gnt_id;
    logic              w_gnt_valid;
    logic              w_grant;

    rr_pick #(
        .RR (RR != 0)
    ) u_pick (
        .req       ({p1_req, p0_req}),
        .prio      (r_prio),
        .gnt_id    (w_gnt_id),
        .gnt_valid (w_gnt_valid)
    );

    assign w_grant = (r_state == ST_IDLE) && w_gnt_valid;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: leave IDLE only when someone requests.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_gnt_valid) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winner's command on grant; drop the write strobe after ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio     <= PORT_CPU;
            r_gnt_id   <= PORT_CPU;
            r_gnt_we   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_dina <= '0;
        end else if (w_grant) begin
            r_gnt_id   <= w_gnt_id;
            r_prio     <= ~w_gnt_id;
            r_gnt_we   <= w_gnt_id ? p1_we : p0_we;
            r_ram_we   <= w_gnt_id ? p1_we : p0_we;
            r_ram_addr <= w_gnt_id ? p1_addr : p0_addr;
            r_ram_dina <= w_gnt_id ? p1_wdata : p0_wdata;
        end else if (r_state == ST_ACCESS) begin
            // The RAM takes the write on the edge closing ACCESS; never repeat it.
            r_ram_we <= 1'b0;
        end
    end

    // Outputs: ack and read data go to the winner only while in DONE.
    always_comb begin
        p0_ack   = 1'b0;
        p1_ack   = 1'b0;
        p0_rdata = '0;
        p1_rdata = '0;
        busy     = (r_state != ST_IDLE);
        if (r_state == ST_DONE) begin
            if (r_gnt_id == PORT_DMA) begin
                p1_ack = 1'b1;
                if (!r_gnt_we) p1_rdata = ram_douta;
            end else begin
                p0_ack = 1'b1;
                if (!r_gnt_we) p0_rdata = ram_douta;
            end
        end
    end

    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_dina = r_ram_dina;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one round-robin instance (k=0) and one fixed-priority
// instance (k=1), each with a synchronous read-first RAM model. Expected acks
// are queued as stimulus is issued and matched in order as acks appear.
module tb_ram_arbiter;
    import arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        int unsigned   k;
        logic          port;
        logic [DW-1:0] rdata;
    } sb_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic          p0_req [2];
    logic          p1_req [2];
    logic          p0_we [2];
    logic          p1_we [2];
    logic [AW-1:0] p0_addr [2];
    logic [AW-1:0] p1_addr [2];
    logic [DW-1:0] p0_wdata [2];
    logic [DW-1:0] p1_wdata [2];
    logic          p0_ack [2];
    logic          p1_ack [2];
    logic [DW-1:0] p0_rdata [2];
    logic [DW-1:0] p1_rdata [2];
    logic          ram_we [2];
    logic [AW-1:0] ram_addr [2];
    logic [DW-1:0] ram_dina [2];
    logic [DW-1:0] ram_douta [2];
    logic          busy [2];

    int n_tests = 0;
    int n_fail  = 0;

    sb_t         sb_q [$];
    int unsigned cyc = 0;
    int unsigned last_ack_cyc = 0;
    bit          have_last = 1'b0;
    bit          gap_chk = 1'b0;
    int unsigned we_cycles [2] = '{0, 0};

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1)) u_rr (
        .clk(clk), .reset(reset),
        .p0_req(p0_req[0]), .p0_we(p0_we[0]), .p0_addr(p0_addr[0]), .p0_wdata(p0_wdata[0]),
        .p0_ack(p0_ack[0]), .p0_rdata(p0_rdata[0]),
        .p1_req(p1_req[0]), .p1_we(p1_we[0]), .p1_addr(p1_addr[0]), .p1_wdata(p1_wdata[0]),
        .p1_ack(p1_ack[0]), .p1_rdata(p1_rdata[0]),
        .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_dina(ram_dina[0]),
        .ram_douta(ram_douta[0]), .busy(busy[0])
    );

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0)) u_fp (
        .clk(clk), .reset(reset),
        .p0_req(p0_req[1]), .p0_we(p0_we[1]), .p0_addr(p0_addr[1]), .p0_wdata(p0_wdata[1]),
        .p0_ack(p0_ack[1]), .p0_rdata(p0_rdata[1]),
        .p1_req(p1_req[1]), .p1_we(p1_we[1]), .p1_addr(p1_addr[1]), .p1_wdata(p1_wdata[1]),
        .p1_ack(p1_ack[1]), .p1_rdata(p1_rdata[1]),
        .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_dina(ram_dina[1]),
        .ram_douta(ram_douta[1]), .busy(busy[1])
    );

    function automatic logic [DW-1:0] preload(input int a);
        return 32'hC0DE_0000 | DW'(a);
    endfunction

    // Synchronous read-first RAM models; contents are filled on the first edge.
    logic [DW-1:0] mem [2][1024];
    logic          filled = 1'b0;
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!filled) begin
                for (int i = 0; i < 1024; i++) mem[k][i] <= preload(i);
            end else if (ram_we[k]) begin
                mem[k][ram_addr[k]] <= ram_dina[k];
            end
            ram_douta[k] <= mem[k][ram_addr[k]];
        end
        filled <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic p, input logic [DW-1:0] r);
        sb_t e;
        e.k = k; e.port = p; e.rdata = r;
        sb_q.push_back(e);
    endtask

    task automatic drive(input int k, input logic p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!p) begin
            p0_req[k] = r; p0_we[k] = w; p0_addr[k] = a; p0_wdata[k] = d;
        end else begin
            p1_req[k] = r; p1_we[k] = w; p1_addr[k] = a; p1_wdata[k] = d;
        end
    endtask

    function automatic logic get_ack(input int k, input logic p);
        return p ? p1_ack[k] : p0_ack[k];
    endfunction

    // Wait (bounded) for the port's ack; lat counts negedges including the one with the ack.
    task automatic wait_ack(input int k, input logic p, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!get_ack(k, p) && lat < 60);
        check("ack_seen", get_ack(k, p), 1'b1);
    endtask

    task automatic access(input int k, input logic p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat);
        @(posedge clk); #1;
        drive(k, p, 1'b1, w, a, d);
        wait_ack(k, p, lat);
    endtask

    task automatic release_port(input int k, input logic p);
        @(posedge clk); #1;
        drive(k, p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // Ack monitor: pop the scoreboard on every ack and compare port and data.
    always @(negedge clk) begin
        sb_t e;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (ram_we[k]) we_cycles[k]++;
            if (p0_ack[k] || p1_ack[k]) begin
                check("one_ack", p0_ack[k] & p1_ack[k], 1'b0);
                check("expected_ack", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("ack_dut", k, e.k);
                    check("ack_port", p1_ack[k], e.port);
                    check("ack_rdata", p1_ack[k] ? p1_rdata[k] : p0_rdata[k], e.rdata);
                    check("idle_rdata", p1_ack[k] ? p0_rdata[k] : p1_rdata[k], 0);
                end
                if (gap_chk && have_last) check("ack_gap", cyc - last_ack_cyc, 3);
                have_last    = 1'b1;
                last_ack_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int unsigned we0;
        for (int k = 0; k < 2; k++) begin
            drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
            drive(k, 1'b1, 1'b0, 1'b0, '0, '0);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state of both instances.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", busy[k], 1'b0);
            check("rst_ram_we", ram_we[k], 1'b0);
            check("rst_ram_addr", ram_addr[k], 0);
            check("rst_ram_dina", ram_dina[k], 0);
            check("rst_p0_ack", p0_ack[k], 1'b0);
            check("rst_p1_ack", p1_ack[k], 1'b0);
            check("rst_p0_rdata", p0_rdata[k], 0);
            check("rst_p1_rdata", p1_rdata[k], 0);
        end

        // Single p0 write then read-back of the same word.
        we0 = we_cycles[0];
        push(0, 1'b0, 32'h0);
        access(0, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, lat);
        check("wr_latency", lat, 3);
        check("done_ram_we", ram_we[0], 1'b0);
        check("done_ram_addr", ram_addr[0], 10'h005);
        check("done_ram_dina", ram_dina[0], 32'hDEADBEEF);
        release_port(0, 1'b0);
        check("wr_we_cycles", we_cycles[0] - we0, 1);
        check("ram_model_wr", mem[0][5], 32'hDEADBEEF);
        push(0, 1'b0, 32'hDEADBEEF);
        access(0, 1'b0, 1'b0, 10'h005, '0, lat);
        check("rd_latency", lat, 3);
        release_port(0, 1'b0);

        // Round-robin: both ports read continuously; grants alternate, 3 cycles apart.
        do_reset();
        have_last = 1'b0;
        gap_chk   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b0, preload(1));
            push(0, 1'b1, preload(2));
        end
        fork
            begin
                int l;
                for (int i = 0; i < 3; i++) access(0, 1'b0, 1'b0, 10'h001, '0, l);
                release_port(0, 1'b0);
            end
            begin
                int l;
                for (int i = 0; i < 3; i++) access(0, 1'b1, 1'b0, 10'h002, '0, l);
                release_port(0, 1'b1);
            end
        join
        gap_chk = 1'b0;

        // Fixed priority: p1 only gets in once p0 drops its request.
        do_reset();
        have_last = 1'b0;
        gap_chk   = 1'b1;
        for (int i = 0; i < 3; i++) push(1, 1'b0, preload(1));
        push(1, 1'b1, preload(2));
        fork
            begin
                int l;
                for (int i = 0; i < 3; i++) access(1, 1'b0, 1'b0, 10'h001, '0, l);
                release_port(1, 1'b0);
            end
            begin
                int l;
                access(1, 1'b1, 1'b0, 10'h002, '0, l);
                release_port(1, 1'b1);
            end
        join
        gap_chk = 1'b0;

        // prio = 1 after a p0 grant: p1 write to 3FF is served before p0 read of 3FF.
        do_reset();
        push(0, 1'b0, preload(7));
        access(0, 1'b0, 1'b0, 10'h007, '0, lat);
        release_port(0, 1'b0);
        push(0, 1'b1, 32'h0);
        push(0, 1'b0, 32'h12345678);
        fork
            begin
                int l;
                access(0, 1'b1, 1'b1, 10'h3FF, 32'h12345678, l);
                release_port(0, 1'b1);
            end
            begin
                int l;
                access(0, 1'b0, 1'b0, 10'h3FF, '0, l);
                release_port(0, 1'b0);
            end
        join

        // Reset during ACCESS of a p0 read: no ack, then the held request is served.
        @(posedge clk); #1 drive(0, 1'b0, 1'b1, 1'b0, 10'h003, '0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rst_acc_busy", busy[0], 1'b1);
        check("rst_acc_ack", p0_ack[0], 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy[0], 1'b0);
        check("post_rst_ram_we", ram_we[0], 1'b0);
        check("post_rst_ack", p0_ack[0], 1'b0);
        push(0, 1'b0, preload(3));
        wait_ack(0, 1'b0, lat);
        check("post_rst_latency", lat, 2);
        release_port(0, 1'b0);

        // Reset during DONE: ack stands, prio returns to 0 so p0 wins the next tie.
        push(0, 1'b0, preload(4));
        @(posedge clk); #1 drive(0, 1'b0, 1'b1, 1'b0, 10'h004, '0);
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rst_done_ack", p0_ack[0], 1'b1);
        @(posedge clk); #1 reset = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_done_next_ack", p0_ack[0], 1'b0);
        check("rst_done_next_busy", busy[0], 1'b0);
        push(0, 1'b0, preload(1));
        push(0, 1'b1, preload(2));
        fork
            begin
                int l;
                access(0, 1'b0, 1'b0, 10'h001, '0, l);
                release_port(0, 1'b0);
            end
            begin
                int l;
                access(0, 1'b1, 1'b0, 10'h002, '0, l);
                release_port(0, 1'b1);
            end
        join

        // p0 re-requests with a new address right after every ack.
        for (int i = 0; i < 5; i++) begin
            push(0, 1'b0, preload(10 + i));
            access(0, 1'b0, 1'b0, AW'(10 + i), '0, lat);
            check("chain_latency", lat, 3);
        end
        release_port(0, 1'b0);

        repeat (6) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_arbiter

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter for the single-port 1K×32 data RAM. It serialises CPU-bus accesses (port 0) and DMA/loader accesses (port 1, e.g. VGA fetch or keyboard buffer fill) onto the RAM wrapper's we/addra/dina/douta port. It sits between the SOC I/O device bus and the RAM wrapper, replacing the direct SOC-to-RAM hookup. Each access uses a req/ack handshake with fixed 3-cycle service.

## Interface
- ADDR_W, 10, RAM word-address width
- DATA_W, 32, RAM data width
- RR, 1, arbitration policy: 1 = round-robin; 0 = fixed priority, port 0 wins

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- p0_req, p1_req  in  1  access request; held high until matching ack
- p0_we, p1_we  in  1  1 = write, 0 = read; stable while req high
- p0_addr, p1_addr  in  ADDR_W  word address; stable while req high
- p0_wdata, p1_wdata  in  DATA_W  write data; stable while req high
- p0_ack, p1_ack  out  1  one-cycle completion pulse
- p0_rdata, p1_rdata  out  DATA_W  read data, valid only while own ack high, else 0
- ram_we  out  1  RAM write enable, to RAM wrapper
- ram_addr  out  ADDR_W  RAM address
- ram_dina  out  DATA_W  RAM write data
- ram_douta  in  DATA_W  RAM read data; synchronous RAM, valid the cycle after address is sampled
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: if any req is high, pick a winner, register addr/we/wdata into ram_*, latch winner id, go to ACCESS; otherwise stay.
  - ACCESS: ram_* held; RAM samples at end of this cycle; go to DONE.
  - DONE: ram_we forced 0; winner's ack = 1; winner's rdata = ram_douta; go to IDLE.
- Winner selection, RR=1: if only one port requests, it wins. If both request, port `prio` wins; after every grant, `prio` is set to the other port.
- Winner selection, RR=0: port 0 wins whenever p0_req is high.
- ram_we is high only during ACCESS, and only for a write. Each write is applied exactly once.
- Write ack: rdata stays 0.
- Read ack: rdata = RAM content at addr before any write in the same transaction.
- ram_addr and ram_dina keep their last values in IDLE and DONE.
- Non-winner req stays pending; no timeout.
- Requester may drop req or present a new request the cycle after ack. IDLE samples only after DONE, so one request is never served twice.
- Out-of-range addresses do not exist; the address is ADDR_W bits with natural wrap.

## Timing
- Reset values: state = IDLE, prio = 0, ram_we = 0, ram_addr = 0, ram_dina = 0, both acks 0, both rdata 0, busy 0.
- Latency: req high in cycle n (state IDLE) → ACCESS in n+1 → ack in n+2.
- Throughput: one access per 3 cycles.
- Back-to-back, both ports requesting continuously, RR=1: grants alternate 0,1,0,1…; each port is served every 6 cycles.
- Simultaneous requests on the same address: served in order. A read after a write by the other port returns the new data.
- Reset asserted in ACCESS: the RAM still samples that edge, so an in-flight write may land. No ack is issued. Next state is IDLE, ram_we = 0.
- Reset asserted in DONE: the ack already visible in that cycle stands. The next cycle is IDLE, with acks 0 and prio = 0.
- A req dropped before ack (protocol violation): the access still completes and the ack still pulses.

## Structure
- Shared package `arb_pkg`:
  - state encodings ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2
  - port ids PORT_CPU = 1'b0, PORT_DMA = 1'b1
  - default RAM widths
- One sub-module `rr_pick`: combinational 2-way picker.
  - inputs: req[1:0], prio, RR
  - outputs: gnt_id, gnt_valid
- The FSM and datapath registers stay in ram_arbiter.

## Test plan
- Reset, then single p0 write addr 10'h005, data 32'hDEADBEEF: ram_we high exactly one cycle (ACCESS); p0_ack in cycle n+2. A later p0 read of 10'h005 gives p0_rdata = 32'hDEADBEEF with its ack.
- Both ports read continuously from addr 1 and addr 2, RR=1: acks alternate p0,p1,p0,p1, 3 cycles apart; each rdata matches RAM preload.
- Same traffic with RR=0: only p0 is acked while p0_req stays high; p1 is served in the first IDLE after p0 drops req.
- Same cycle, p1 write 10'h3FF = 32'h12345678 and p0 read 10'h3FF with prio = 1: p1 is acked first; p0 then reads 32'h12345678.
- Reset pulsed during ACCESS of a p0 read: no p0_ack. One cycle after reset: busy = 0, ram_we = 0, prio = 0. The re-held req is served normally in 3 cycles.
- After each p0 ack, p0 holds req with a new address: no double ack for the old request; each address is acked exactly once.
